// File: rtl/vgpr_pkg.sv
// Shared definitions for the parametrised VGPR register file: default geometry,
// sequencer state encoding and the wrapped dword address helper.
package vgpr_pkg;

    localparam int VGPR_ADDR_W    = 10;
    localparam int VGPR_DATA_W    = 32;
    localparam int VGPR_NUM_RD    = 3;
    localparam int VGPR_NUM_WR_DW = 4;

    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } vgpr_state_e;

    // Address of dword k of a burst starting at base, modulo 2**addr_w.
    function automatic logic [31:0] vgpr_wrap_addr(input logic [31:0] base,
                                                   input logic [31:0] k,
                                                   input int unsigned addr_w);
        logic [31:0] mask;
        mask = (addr_w >= 32) ? '1 : ((32'd1 << addr_w) - 32'd1);
        return (base + k) & mask;
    endfunction

endpackage

// File: rtl/vgpr_init_seq.sv
// Post-reset zero-fill sequencer: walks every entry once, then parks in READY
// and raises init_done. state_dbg exposes the FSM state.
module vgpr_init_seq
    import vgpr_pkg::*;
#(
    parameter int ADDR_W = VGPR_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    output logic              init_we,
    output logic [ADDR_W-1:0] init_addr,
    output logic              init_done,
    output logic              state_dbg
);

    vgpr_state_e       state_q, state_d;
    logic [ADDR_W-1:0] init_cnt_q, init_cnt_d;
    logic              init_done_q, init_done_d;

    always_comb begin
        state_d     = state_q;
        init_cnt_d  = init_cnt_q;
        init_done_d = init_done_q;
        if (state_q == ST_INIT) begin
            init_cnt_d = init_cnt_q + ADDR_W'(1);
            // Last entry is written this cycle; READY and init_done follow together.
            if (init_cnt_q == '1) begin
                state_d     = ST_READY;
                init_done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_INIT;
            init_cnt_q  <= '0;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            init_cnt_q  <= init_cnt_d;
            init_done_q <= init_done_d;
        end
    end

    assign init_we   = (state_q == ST_INIT) && !rst;
    assign init_addr = init_cnt_q;
    assign init_done = init_done_q;
    assign state_dbg = state_q;

endmodule

// File: rtl/vgpr_regfile_nr1w.sv
// N-read / 1-write (multi-dword, wrapping) VGPR register file with registered reads.
// Define VGPR_RD_BYPASS_EN for write-first same-cycle reads; default is read-first.
module vgpr_regfile_nr1w
    import vgpr_pkg::*;
#(
    parameter int ADDR_W    = VGPR_ADDR_W,
    parameter int DATA_W    = VGPR_DATA_W,
    parameter int NUM_RD    = VGPR_NUM_RD,
    parameter int NUM_WR_DW = VGPR_NUM_WR_DW
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_RD-1:0]           rd_en,
    input  logic [NUM_RD*ADDR_W-1:0]    rd_addr,
    output logic [NUM_RD*DATA_W-1:0]    rd_data,
    output logic [NUM_RD-1:0]           rd_valid,
    input  logic [ADDR_W-1:0]           wr_addr,
    input  logic [NUM_WR_DW-1:0]        wr_en,
    input  logic [NUM_WR_DW*DATA_W-1:0] wr_data,
    output logic                        init_done
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic              init_we;
    logic [ADDR_W-1:0] init_addr;
    logic              seq_state;
    logic              ready;

    vgpr_init_seq #(.ADDR_W(ADDR_W)) u_init_seq (
        .clk       (clk),
        .rst       (rst),
        .init_we   (init_we),
        .init_addr (init_addr),
        .init_done (init_done),
        .state_dbg (seq_state)
    );

    assign ready = (vgpr_state_e'(seq_state) == ST_READY);

    logic [ADDR_W-1:0] ext_waddr [NUM_WR_DW];
    logic [ADDR_W-1:0] rd_addr_a [NUM_RD];

    always_comb begin
        for (int k = 0; k < NUM_WR_DW; k++) begin
            ext_waddr[k] = ADDR_W'(vgpr_wrap_addr(32'(wr_addr), 32'(k), ADDR_W));
        end
        for (int p = 0; p < NUM_RD; p++) begin
            rd_addr_a[p] = rd_addr[p*ADDR_W +: ADDR_W];
        end
    end

    // Write port mux: the init sequencer borrows lane 0 and locks out external writes.
    logic              mem_we    [NUM_WR_DW];
    logic [ADDR_W-1:0] mem_waddr [NUM_WR_DW];
    logic [DATA_W-1:0] mem_wdata [NUM_WR_DW];

    always_comb begin
        for (int k = 0; k < NUM_WR_DW; k++) begin
            mem_we[k]    = ready && !rst && wr_en[k];
            mem_waddr[k] = ext_waddr[k];
            mem_wdata[k] = wr_data[k*DATA_W +: DATA_W];
        end
        if (init_we) begin
            mem_we[0]    = 1'b1;
            mem_waddr[0] = init_addr;
            mem_wdata[0] = '0;
        end
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < NUM_WR_DW; k++) begin
            if (mem_we[k]) begin
                mem_q[mem_waddr[k]] <= mem_wdata[k];
            end
        end
    end

    logic [NUM_RD*DATA_W-1:0] rd_data_q, rd_data_d;
    logic [NUM_RD-1:0]        rd_valid_q, rd_valid_d;

    always_comb begin
        rd_data_d  = rd_data_q;
        rd_valid_d = '0;
        for (int p = 0; p < NUM_RD; p++) begin
            rd_valid_d[p] = ready && rd_en[p];
            if (rd_valid_d[p]) begin
                rd_data_d[p*DATA_W +: DATA_W] = mem_q[rd_addr_a[p]];
`ifdef VGPR_RD_BYPASS_EN
                for (int k = 0; k < NUM_WR_DW; k++) begin
                    if (wr_en[k] && (ext_waddr[k] == rd_addr_a[p])) begin
                        rd_data_d[p*DATA_W +: DATA_W] = wr_data[k*DATA_W +: DATA_W];
                    end
                end
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_q  <= '0;
            rd_valid_q <= '0;
        end else begin
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;

endmodule

// File: tb/tb_vgpr_regfile_nr1w.sv
// Directed + random bench for vgpr_regfile_nr1w with a reference array model and
// expected-value queues popped one cycle after each stimulus step.
module tb_vgpr_regfile_nr1w;

    localparam int ADDR_W    = 10;
    localparam int DATA_W    = 32;
    localparam int NUM_RD    = 3;
    localparam int NUM_WR_DW = 4;
    localparam int DEPTH     = 1024;

    logic                        clk = 1'b0;
    logic                        rst;
    logic [NUM_RD-1:0]           rd_en;
    logic [NUM_RD*ADDR_W-1:0]    rd_addr;
    logic [NUM_RD*DATA_W-1:0]    rd_data;
    logic [NUM_RD-1:0]           rd_valid;
    logic [ADDR_W-1:0]           wr_addr;
    logic [NUM_WR_DW-1:0]        wr_en;
    logic [NUM_WR_DW*DATA_W-1:0] wr_data;
    logic                        init_done;

    vgpr_regfile_nr1w #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .NUM_RD    (NUM_RD),
        .NUM_WR_DW (NUM_WR_DW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .wr_addr   (wr_addr),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .init_done (init_done)
    );

    always #5 clk = ~clk;

    logic [DATA_W-1:0] mem_m   [DEPTH];
    logic [DATA_W-1:0] rd_last [NUM_RD];
    int                init_left;
    int                checks = 0;
    int                errors = 0;

    logic [DATA_W-1:0] exp_q [$];
    logic [NUM_RD-1:0] vld_q [$];
    logic              done_q [$];

    task automatic cycle(input logic r, input logic [2:0] re,
                         input logic [9:0] a0, input logic [9:0] a1, input logic [9:0] a2,
                         input logic [3:0] we, input logic [9:0] wa,
                         input logic [31:0] d0, input logic [31:0] d1,
                         input logic [31:0] d2, input logic [31:0] d3);
        logic [9:0]  ra [3];
        logic [31:0] wd [4];
        logic [31:0] v;
        logic [31:0] got;
        logic [31:0] e;
        logic [9:0]  wk;
        logic [2:0]  ev;
        logic        ed;
        logic        ready_m;
        ra[0] = a0; ra[1] = a1; ra[2] = a2;
        wd[0] = d0; wd[1] = d1; wd[2] = d2; wd[3] = d3;
        rst     = r;
        rd_en   = re;
        rd_addr = {a2, a1, a0};
        wr_en   = we;
        wr_addr = wa;
        wr_data = {d3, d2, d1, d0};
        ready_m = !r && (init_left == 0);
        for (int p = 0; p < NUM_RD; p++) begin
            if (r) begin
                v = '0;
            end else if (ready_m && re[p]) begin
                v = mem_m[ra[p]];
`ifdef VGPR_RD_BYPASS_EN
                for (int k = 0; k < NUM_WR_DW; k++) begin
                    wk = wa + 10'(k);
                    if (we[k] && wk == ra[p]) v = wd[k];
                end
`endif
            end else begin
                v = rd_last[p];
            end
            rd_last[p] = v;
            exp_q.push_back(v);
        end
        vld_q.push_back(ready_m ? re : 3'b000);
        if (ready_m) begin
            for (int k = 0; k < NUM_WR_DW; k++) begin
                wk = wa + 10'(k);
                if (we[k]) mem_m[wk] = wd[k];
            end
        end
        if (r) begin
            init_left = DEPTH;
            for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
        end else if (init_left > 0) begin
            init_left--;
        end
        done_q.push_back(!r && init_left == 0);

        @(posedge clk);
        #1;
        for (int p = 0; p < NUM_RD; p++) begin
            e   = exp_q.pop_front();
            got = rd_data[p*DATA_W +: DATA_W];
            checks++;
            assert (got === e) else begin
                errors++;
                $error("FAIL rd_data[%0d] observed %h expected %h", p, got, e);
            end
        end
        ev = vld_q.pop_front();
        checks++;
        assert (rd_valid === ev) else begin
            errors++;
            $error("FAIL rd_valid observed %b expected %b", rd_valid, ev);
        end
        ed = done_q.pop_front();
        checks++;
        assert (init_done === ed) else begin
            errors++;
            $error("FAIL init_done observed %b expected %b", init_done, ed);
        end
    endtask

    task automatic idle();
        cycle(1'b0, 3'b000, 10'd0, 10'd0, 10'd0, 4'b0000, 10'd0, 32'd0, 32'd0, 32'd0, 32'd0);
    endtask

    task automatic rd(input logic [2:0] re, input logic [9:0] a0, input logic [9:0] a1,
                      input logic [9:0] a2);
        cycle(1'b0, re, a0, a1, a2, 4'b0000, 10'd0, 32'd0, 32'd0, 32'd0, 32'd0);
    endtask

    task automatic wr(input logic [3:0] we, input logic [9:0] wa,
                      input logic [31:0] d0, input logic [31:0] d1,
                      input logic [31:0] d2, input logic [31:0] d3);
        cycle(1'b0, 3'b000, 10'd0, 10'd0, 10'd0, we, wa, d0, d1, d2, d3);
    endtask

    task automatic do_reset();
        cycle(1'b1, 3'b000, 10'd0, 10'd0, 10'd0, 4'b0000, 10'd0, 32'd0, 32'd0, 32'd0, 32'd0);
    endtask

    task automatic wait_ready();
        for (int i = 0; i < DEPTH + 8 && init_left > 0; i++) idle();
    endtask

    function automatic logic [9:0] rnd_addr();
        if ($urandom_range(0, 1) == 0) return 10'($urandom_range(0, 15));
        return 10'($urandom_range(1018, 1023));
    endfunction

    initial begin
        init_left = DEPTH;
        for (int p = 0; p < NUM_RD; p++) rd_last[p] = '0;

        // Init: zero-fill timing and contents at both ends and the middle.
        do_reset();
        wait_ready();
        rd(3'b111, 10'd0, 10'd511, 10'd1023);
        idle();

        // Basic write, one-cycle read latency, multi-port same address.
        wr(4'b0001, 10'd5, 32'hDEADBEEF, 32'd0, 32'd0, 32'd0);
        rd(3'b001, 10'd5, 10'd0, 10'd0);
        rd(3'b110, 10'd0, 10'd5, 10'd5);

        // Wrapping four-dword burst and a sparse enable mask.
        wr(4'b1111, 10'd1022, 32'd1, 32'd2, 32'd3, 32'd4);
        rd(3'b111, 10'd1022, 10'd1023, 10'd0);
        rd(3'b001, 10'd1, 10'd0, 10'd0);
        wr(4'b1111, 10'd100, 32'h10, 32'h11, 32'h12, 32'h13);
        wr(4'b1010, 10'd100, 32'hA0, 32'hA1, 32'hA2, 32'hA3);
        rd(3'b111, 10'd100, 10'd101, 10'd102);
        rd(3'b001, 10'd103, 10'd0, 10'd0);

        // Same-cycle read/write of one entry.
        wr(4'b0001, 10'd7, 32'hAA, 32'd0, 32'd0, 32'd0);
        cycle(1'b0, 3'b010, 10'd0, 10'd7, 10'd0, 4'b0001, 10'd7, 32'hBB, 32'd0, 32'd0, 32'd0);
        rd(3'b010, 10'd0, 10'd7, 10'd0);

        // Random mix concentrated on a few low and wrapping addresses.
        for (int i = 0; i < 300; i++) begin
            cycle(1'b0, 3'($urandom_range(0, 7)), rnd_addr(), rnd_addr(), rnd_addr(),
                  4'($urandom_range(0, 15)), rnd_addr(),
                  $urandom, $urandom, $urandom, $urandom);
        end

        // Reset from READY, plus writes and reads attempted during INIT.
        wr(4'b0001, 10'd9, 32'h77, 32'd0, 32'd0, 32'd0);
        rd(3'b001, 10'd9, 10'd0, 10'd0);
        do_reset();
        for (int i = 0; i < 9; i++) idle();
        cycle(1'b0, 3'b111, 10'd3, 10'd3, 10'd3, 4'b0001, 10'd3, 32'h55, 32'd0, 32'd0, 32'd0);
        wait_ready();
        rd(3'b011, 10'd9, 10'd3, 10'd0);
        idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
